reg_load_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit loadable register (load/d/q storage element) among N requesters. Each requester presents data and raises a request. The arbiter picks one winner, captures its data, and drives the register's `load`/`d` inputs for exactly one cycle. It then acknowledges the winner. The block sits directly in front of the shared register; the register's `q` is not an input to this block.

---
 rtl/reg_load_arbiter.sv | 101 ++++++++++
 tb/tb_reg_load_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that feeds one shared W-bit loadable register from N requesters.
// Each transfer runs IDLE (pick and capture) -> LOAD (drive load/d) -> ACK (pulse ack).
module reg_load_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic           load,
  output logic [W-1:0]   d,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  d_q, d_d;

  logic          found;
  logic [IW-1:0] win;

  // Scanning from the far end back toward ptr leaves the first asserted
  // requester at or after ptr (wrapping modulo N) as the final winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    d_d     = d_q;
    gnt     = '0;
    ack     = '0;
    load    = 1'b0;
    busy    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          idx_d   = win;
          d_d     = data[int'(win)*W +: W];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        gnt     = N'(1) << idx_q;
        busy    = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        gnt     = N'(1) << idx_q;
        ack     = N'(1) << idx_q;
        busy    = 1'b1;
        ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
    end
  end

  assign d = d_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed self-checking bench for reg_load_arbiter (N=4, W=4), with a model
// of the shared register it drives.
module tb_reg_load_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   gnt, ack;
  logic           load, busy;
  logic [W-1:0]   d;
  logic [W-1:0]   q_model;

  int n_checks = 0;
  int n_fail   = 0;

  reg_load_arbiter #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .ack  (ack),
    .load (load),
    .d    (d),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // The shared register sitting behind the arbiter.
  always @(posedge clk) begin
    if (rst)       q_model <= '0;
    else if (load) q_model <= d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_ack,
                            input logic e_load, input logic [3:0] e_d, input logic e_busy);
    check({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
    check({tag, ".ack"},  32'(ack),  32'(e_ack));
    check({tag, ".load"}, 32'(load), 32'(e_load));
    check({tag, ".d"},    32'(d),    32'(e_d));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  initial begin
    // Reset held two cycles with busy-looking inputs.
    rst  = 1'b1;
    req  = 4'b1010;
    data = 16'h5A3C;
    tick();
    expect_out("rst_c1", 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
    tick();
    expect_out("rst_c2", 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    req = '0;
    tick();
    expect_out("idle_a", 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
    tick();
    expect_out("idle_b", 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);

    // Single requester 0 with data 4'hC.
    req  = 4'b0001;
    data = 16'h000C;
    tick();
    expect_out("single_load", 4'b0001, 4'b0000, 1'b1, 4'hC, 1'b1);
    tick();
    expect_out("single_ack", 4'b0001, 4'b0001, 1'b0, 4'hC, 1'b1);
    check("single_q", 32'(q_model), 32'h C);
    tick();
    req = '0;
    expect_out("single_idle", 4'b0000, 4'b0000, 1'b0, 4'hC, 1'b0);
    tick();
    expect_out("single_rest", 4'b0000, 4'b0000, 1'b0, 4'hC, 1'b0);

    // All four requesting after reset: served 0,1,2,3 then 0 again.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b1111;
    data = 16'hBA98;
    for (int t = 0; t < 4; t++) begin
      tick();
      expect_out($sformatf("all_load%0d", t), 4'(1 << t), 4'b0000, 1'b1, 4'(8 + t), 1'b1);
      tick();
      expect_out($sformatf("all_ack%0d", t), 4'(1 << t), 4'(1 << t), 1'b0, 4'(8 + t), 1'b1);
      check($sformatf("all_q%0d", t), 32'(q_model), 32'(8 + t));
      tick();
      check($sformatf("all_idle_busy%0d", t), 32'(busy), 32'd0);
    end
    tick();
    expect_out("all_wrap_load", 4'b0001, 4'b0000, 1'b1, 4'h8, 1'b1);
    tick();
    tick();
    req = '0;

    // Fairness: requesters 0 and 2 keep re-requesting.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b0101;
    data = 16'h0705;
    for (int t = 0; t < 4; t++) begin
      tick();
      check($sformatf("fair_gnt%0d", t), 32'(gnt), (t % 2 == 0) ? 32'h1 : 32'h4);
      check($sformatf("fair_d%0d", t),   32'(d),   (t % 2 == 0) ? 32'h5 : 32'h7);
      tick();
      check($sformatf("fair_ack%0d", t), 32'(ack), (t % 2 == 0) ? 32'h1 : 32'h4);
      tick();
    end
    req = '0;
    tick();

    // Data changing during LOAD must not disturb the captured value.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b0001;
    data = 16'h0003;
    tick();
    data = 16'h000F;
    expect_out("stab_load", 4'b0001, 4'b0000, 1'b1, 4'h3, 1'b1);
    tick();
    expect_out("stab_ack", 4'b0001, 4'b0001, 1'b0, 4'h3, 1'b1);
    tick();
    check("stab_idle_d", 32'(d), 32'h3);
    tick();
    expect_out("stab_reload", 4'b0001, 4'b0000, 1'b1, 4'hF, 1'b1);
    tick();
    tick();
    req = '0;
    tick();

    // Reset during LOAD with ptr left at 1 by the previous transfer.
    req  = 4'b0100;
    data = 16'h0D0E;
    tick();
    expect_out("rl_load", 4'b0100, 4'b0000, 1'b1, 4'hD, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0101;
    expect_out("rl_after", 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0);
    tick();
    expect_out("rl_regrant", 4'b0001, 4'b0000, 1'b1, 4'hE, 1'b1);
    tick();
    check("rl_ack0", 32'(ack), 32'h1);
    req = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
